fifo_lfsr_reader: RTL

Read-side streaming engine for the LFSR-pointer synchronous FIFO. It drives the FIFO read request, captures the one-cycle-late read data into a small skid buffer, and presents words downstream on a valid/ready stream at full throughput. There is no combinational path from the downstream ready to the FIFO read request. An optional LFSR-style signature register compacts every delivered word for built-in self-test.

---
 rtl/fifo_lfsr_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_lfsr_reader.sv
// fifo_lfsr_reader: read-side streaming engine for the LFSR-pointer FIFO.
// Issues FIFO reads, catches the one-cycle-late data in a skid buffer and
// streams it out on valid/ready at one word per cycle.
// Optional feature macro: FIFO_READER_SIGNATURE_EN (signature register).
module fifo_lfsr_reader #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            SKID_DEPTH = 3,
  parameter logic [DATA_WIDTH-1:0]  SIG_POLY   = DATA_WIDTH'(8'h1D),
  localparam int unsigned           OCC_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OCC_W-1:0]      occupancy,
  output logic [DATA_WIDTH-1:0] signature
);

  localparam int unsigned IDX_W = $clog2(SKID_DEPTH);
  localparam int unsigned CNT_W = OCC_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [IDX_W-1:0]      head_q, head_d;
  logic [IDX_W-1:0]      tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  capture_c;
  logic                  pop_c;
  logic [CNT_W-1:0]      pending_c;

  // Wrap by compare-and-clear so non-power-of-two depths work.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(SKID_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  assign m_valid   = (occ_q != '0);
  assign m_data    = mem_q[head_q];
  assign occupancy = occ_q;

  // Read issue from registered state only; no path from m_ready.
  always_comb begin
    pending_c  = CNT_W'(occ_q) + CNT_W'(inflight_q);
    fifo_rd_en = !fifo_empty && !flush && (pending_c < CNT_W'(SKID_DEPTH));
  end

  // Next-state for indices, occupancy and the in-flight flag.
  always_comb begin
    capture_c  = inflight_q && !flush;
    pop_c      = m_valid && m_ready;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
      inflight_d = 1'b0;
    end else begin
      if (capture_c) tail_d = idx_inc(tail_q);
      if (pop_c)     head_d = idx_inc(head_q);
      case ({capture_c, pop_c})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  // Skid buffer storage; the word arriving in a flush cycle is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) mem_q[i] <= '0;
    end else if (capture_c) begin
      mem_q[tail_q] <= fifo_data;
    end
  end

`ifdef FIFO_READER_SIGNATURE_EN
  logic [DATA_WIDTH-1:0] sig_q, sig_d;

  // Compact each delivered word; flush-cycle pops still count.
  always_comb begin
    sig_d = sig_q;
    if (pop_c) begin
      sig_d = {sig_q[DATA_WIDTH-2:0], 1'b0}
            ^ (sig_q[DATA_WIDTH-1] ? SIG_POLY : '0)
            ^ m_data;
    end
  end

  // Signature register, cleared by reset only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sig_q <= '0;
    else      sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  // Feature compiled out: constant zero, polynomial kept referenced.
  assign signature = SIG_POLY & DATA_WIDTH'(0);
`endif

endmodule
